// File: rtl/clm_inverse_ctrl_pkg.sv
// Shared types for the CLM GF(2^8) inverse sequencer.
// Element width is 8+CLM_D bits (CLM redundancy bits on top of the byte).
package clm_inverse_ctrl_pkg;

    localparam int CLM_D      = 2;
    localparam int STEP_COUNT = 11;

    typedef logic [8+CLM_D-1:0] state_t;
    typedef logic [7:0]         red_poly_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } inv_state_e;

    typedef enum logic [2:0] {
        SRC_X,
        SRC_T2,
        SRC_T3,
        SRC_T12,
        SRC_A
    } inv_src_e;

endpackage

// File: rtl/clm_inv_step_rom.sv
// Addition-chain program for x^254: per step, the two operand sources,
// the destination register and whether the product is also kept as x^12.
module clm_inv_step_rom
    import clm_inverse_ctrl_pkg::*;
(
    input  logic [3:0] step,
    output inv_src_e   src_a,
    output inv_src_e   src_b,
    output inv_src_e   dest,
    output logic       also_t12
);

    always_comb begin
        src_a    = SRC_A;
        src_b    = SRC_A;
        dest     = SRC_A;
        also_t12 = 1'b0;
        unique case (step)
            4'd0: begin
                src_a = SRC_X;
                src_b = SRC_X;
                dest  = SRC_T2;
            end
            4'd1: begin
                src_a = SRC_T2;
                src_b = SRC_X;
                dest  = SRC_T3;
            end
            4'd2: begin
                src_a = SRC_T3;
                src_b = SRC_T3;
            end
            4'd3: also_t12 = 1'b1;
            4'd4: src_b = SRC_T3;
            4'd9: src_b = SRC_T12;
            4'd10: src_b = SRC_T2;
            default: ;
        endcase
    end

endmodule

// File: rtl/clm_inverse_ctrl.sv
// Drives one serial CLM multiplier through 11 squarings/products to get x^254.
// Optional CLM_INV_ABORT_EN adds an abort input that drops back to IDLE.
module clm_inverse_ctrl
    import clm_inverse_ctrl_pkg::*;
#(
    parameter int d = CLM_D
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CLM_INV_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic [8+d-1:0]  x_in,
    input  red_poly_t       P,
    output logic            busy,
    output logic            done,
    output logic [8+d-1:0]  result,
    output logic [8+d-1:0]  mul_p1,
    output logic [8+d-1:0]  mul_p2,
    output logic            mul_drdy_i,
    input  logic [8+d-1:0]  mul_out,
    input  logic            mul_drdy_o,
    output red_poly_t       mul_P
);

    localparam int W = 8 + d;

    inv_state_e     state, next_state;
    logic [W-1:0]   x, t2, t3, t12, a;
    logic [3:0]     step;
    inv_src_e       src_a, src_b, dest;
    logic           also_t12;
    logic           load, capture, last;

    clm_inv_step_rom u_rom (
        .step     (step),
        .src_a    (src_a),
        .src_b    (src_b),
        .dest     (dest),
        .also_t12 (also_t12)
    );

    function automatic logic [W-1:0] pick(input inv_src_e s);
        logic [W-1:0] v;
        v = a;
        unique case (s)
            SRC_X:   v = x;
            SRC_T2:  v = t2;
            SRC_T3:  v = t3;
            SRC_T12: v = t12;
            SRC_A:   v = a;
            default: v = a;
        endcase
        return v;
    endfunction

    assign mul_p1     = pick(src_a);
    assign mul_p2     = pick(src_b);
    assign mul_P      = P;
    assign mul_drdy_i = (state == ISSUE);
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    assign last       = (step == 4'(STEP_COUNT - 1));

    // In ISSUE the multiplier's ready flag is still the previous product's.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (mul_drdy_o) begin
                    capture    = 1'b1;
                    next_state = last ? DONE : ISSUE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
`ifdef CLM_INV_ABORT_EN
        if (abort && state != IDLE) begin
            next_state = IDLE;
            capture    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            t2     <= '0;
            t3     <= '0;
            t12    <= '0;
            a      <= '0;
            step   <= '0;
            result <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                x    <= x_in;
                step <= '0;
            end
            if (capture) begin
                unique case (dest)
                    SRC_T2:  t2 <= mul_out;
                    SRC_T3:  t3 <= mul_out;
                    SRC_A:   a  <= mul_out;
                    default: ;
                endcase
                if (also_t12)
                    t12 <= mul_out;
                if (last)
                    result <= mul_out;
                else
                    step <= step + 4'd1;
            end
        end
    end

endmodule

// File: doc/clm_inverse_ctrl.md
# clm_inverse_ctrl

Sequencing controller that drives the serial CLM multiplier through its `multiplier_io_if` requester side to compute the GF(2^8) inverse x^254 of a CLM-encoded (8+d)-bit element. It holds intermediate powers, issues 11 multiplications one at a time (operand pulse, wait for result ready), and returns the encoded result. It sits between the masked S-box datapath and one multiplier instance, and shares that multiplier's clock and reset.

## Interface
- `d`, default 2: CLM redundancy bits; element width 8+d.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `x_in` in 8+d: encoded operand (`state_t`), sampled with `start`.
- `P` in 8: field polynomial, low 8 bits (AES: 8'h1B); forwarded unchanged to the multiplier's P input.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 8+d: encoded x^254; holds until the next accepted `start`.
- `mul_p1`, `mul_p2` out 8+d: multiplier operands.
- `mul_drdy_i` out 1: one-cycle operand-valid pulse to the multiplier.
- `mul_out` in 8+d: multiplier product.
- `mul_drdy_o` in 1: multiplier result-ready. It stays high after completion until the next `mul_drdy_i` is sampled.
- `mul_P` out 8: equals `P`.
- `abort` in 1: present only with CLM_INV_ABORT_EN.

## Operation
- Registers: X, T2, T3, T12, A, and a 4-bit step counter (0..10). All reset to 0.
- Step program (dest = a*b):
  - 0: T2=X*X
  - 1: T3=T2*X
  - 2: A=T3*T3
  - 3: A=A*A, also written to T12 (x^12)
  - 4: A=A*T3 (x^15)
  - 5–8: A=A*A (x^240)
  - 9: A=A*T12 (x^252)
  - 10: A=A*T2 (x^254)
- FSM states:
  - IDLE: on `start`, X←x_in, step←0, go to ISSUE.
  - ISSUE: `mul_drdy_i`=1; `mul_p1`/`mul_p2` = step operands a/b; go to WAIT. `mul_drdy_o` is ignored in this state because it is stale from the previous product.
  - WAIT: on `mul_drdy_o`, write `mul_out` to the destination register(s). If step==10, also load `result` and go to DONE. Otherwise step+1 and go to ISSUE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `mul_p1`/`mul_p2` are driven from the step mux in every state. Only the ISSUE-cycle values are meaningful.
- Correctness contract: `result` reduced mod (x^8+P) equals the GF(2^8) inverse of `x_in` reduced mod (x^8+P). For input 0 the reduced result is 0.
- Boundary conditions:
  - `start` while busy: ignored.
  - `mul_drdy_o` seen in IDLE or DONE: ignored.
  - `rst` mid-operation: next cycle is IDLE; all outputs are 0, including `mul_drdy_i` and `result`.
  - `start` in the same cycle as `rst`: `rst` wins.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `mul_drdy_i`=0, `mul_p1`=0, `mul_p2`=0.
- `start` sampled at edge s → ISSUE during cycle s+1.
- Each step takes 10+d cycles: ISSUE (1) + multiplier run (8+d) + WAIT capture (1).
- `done` is asserted in cycle s+1+11·(10+d); for d=2 that is s+133. The next `start` is accepted in the cycle after `done`.
- `mul_drdy_i` is never high in two consecutive cycles.

## Configuration
- `CLM_INV_ABORT_EN`:
  - Defined: adds the `abort` input. `abort` in any non-IDLE state returns the FSM to IDLE next cycle with no `done` pulse; `result` is unchanged. `abort` in IDLE has no effect.
  - Undefined: no port and no logic.

## Structure
- `types` package: `state_t`, `red_poly_t`; the `inv_state_e` enum (IDLE/ISSUE/WAIT/DONE); the `inv_src_e` operand-select enum (X/T2/T3/T12/A); the step-count constant 11.
- One sub-module, `clm_inv_step_rom`: combinational. Maps step → {src_a, src_b, dest, also_T12}.

## Test plan
Every scenario uses d=2, P=8'h1B, and a behavioural multiplier model with 8+d latency and sticky `mul_drdy_o`.
1. `x_in` encoding 8'h53 (zero redundancy) → `done` at s+133; `result` mod P = 8'hCA; exactly 11 `mul_drdy_i` pulses, spaced 12 cycles apart.
2. `x_in` encoding 8'h01 plus random r·P redundancy → reduced result 8'h01. `x_in` encoding 8'h02 → reduced result 8'h8D.
3. `x_in`=0 → reduced result 0. Back-to-back request (`start` in the cycle after `done`) → second `done` 133 cycles later.
4. `start` re-pulsed at cycles s+5 and s+60 → ignored; a single `done` at s+133.
5. `rst` at s+40 → cycle s+41: IDLE, `busy`=0, `result`=0. Late `mul_drdy_o` from the model produces no register write.
6. With CLM_INV_ABORT_EN: `abort` at s+70 → IDLE at s+71, no `done`, `result` keeps its previous value. A new `start` then completes normally.
